// File: rtl/pipe_pkg.sv
// Shared types for the ID/EX pipeline stage: decoded control bundle,
// skid-buffer state encoding and the all-zero control word.
package pipe_pkg;

  localparam int unsigned A3_W = 4;

  typedef struct packed {
    logic            RF_WE;
    logic [A3_W-1:0] A3;
    logic [1:0]      BranchSelect;
    logic            ALUOpBSelect;
    logic [1:0]      ALUControl;
    logic            SetFlags;
    logic            MemWE;
    logic            WBSelect;
  } id_ex_ctrl_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam id_ex_ctrl_t CTRL_NOP = '0;

  // Side-effecting strobes must never fire on a bubble.
  function automatic id_ex_ctrl_t gate_strobes(input id_ex_ctrl_t c, input logic v);
    id_ex_ctrl_t g;
    g = c;
    if (!v) begin
      g.RF_WE        = 1'b0;
      g.MemWE        = 1'b0;
      g.SetFlags     = 1'b0;
      g.BranchSelect = '0;
    end
    return g;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer with synchronous flush.
// Ready is decoded from the state register only, so it is fully registered.
import pipe_pkg::*;

module pipe_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  pipe_state_t  r_state;
  pipe_state_t  w_state_nxt;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         w_accept;
  logic         w_pop;
  logic         w_load_main_in;
  logic         w_load_main_skid;
  logic         w_load_skid;

  assign o_ready  = (r_state != FULL);
  assign o_valid  = (r_state != EMPTY);
  assign o_data   = r_main;
  assign w_accept = i_valid && o_ready && !i_flush;
  assign w_pop    = o_valid && i_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (i_flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_load_main_in = 1'b1;
            w_state_nxt    = ONE;
          end
        end
        ONE: begin
          if (w_accept && w_pop) begin
            w_load_main_in = 1'b1;
          end else if (w_accept) begin
            w_load_skid = 1'b1;
            w_state_nxt = FULL;
          end else if (w_pop) begin
            w_state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            w_load_main_skid = 1'b1;
            w_state_nxt      = ONE;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main <= i_data;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= i_data;
      end
    end
  end

endmodule

// File: rtl/pipe_id_ex_skid.sv
// ID/EX stage: skid-buffered operands, immediate and control, with strobe
// gating on bubbles and a saturating backpressure (stall) counter.
import pipe_pkg::*;

module pipe_id_ex_skid #(
  parameter int unsigned N     = 32,
  parameter int unsigned LANES = 4,
  parameter int unsigned A3W   = 4,
  parameter int unsigned CNTW  = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  input  logic [LANES*N-1:0]   RD1_i,
  input  logic [LANES*N-1:0]   RD2_i,
  input  logic [N-1:0]         Extend_i,
  input  id_ex_ctrl_t          Ctrl_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*N-1:0]   RD1_o,
  output logic [LANES*N-1:0]   RD2_o,
  output logic [N-1:0]         Extend_o,
  output id_ex_ctrl_t          Ctrl_o,
  output logic [CNTW-1:0]      stall_cnt
);

  localparam int unsigned PW = 2 * LANES * N + N + $bits(id_ex_ctrl_t);

  // The control struct fixes the destination index width to the register file's.
  if (A3W != A3_W) begin : g_a3w_mismatch
    $error("pipe_id_ex_skid: A3W must equal pipe_pkg::A3_W");
  end

  logic [PW-1:0]   w_payload_in;
  logic [PW-1:0]   w_payload_out;
  id_ex_ctrl_t     w_ctrl_q;
  logic [CNTW-1:0] r_stall_cnt;

  assign w_payload_in = {RD1_i, RD2_i, Extend_i, Ctrl_i};

  pipe_skid_buf #(
    .W (PW)
  ) u_skid (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_flush (flush),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_payload_in),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_payload_out)
  );

  assign {RD1_o, RD2_o, Extend_o, w_ctrl_q} = w_payload_out;

  always_comb begin
    Ctrl_o = gate_strobes(w_ctrl_q, out_valid);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stall_cnt <= '0;
    end else if (in_valid && !in_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNTW'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/pipe_id_ex_skid.md
# pipe_id_ex_skid

Parametrised ID/EX pipeline stage for the vector datapath, placed between decode (register file read, extend, control decode) and execute. It registers the vector operands, the scalar immediate and the decoded control bundle, using a valid/ready handshake and a two-entry skid buffer. Decode therefore sees a backpressure signal that is fully registered. The stage also supports a synchronous flush for branch redirect, gates control strobes on bubbles, and keeps a saturating stall counter.

## Interface
- N, 32, element width in bits
- LANES, 4, vector lanes per operand; rd1/rd2 buses are LANES*N bits
- A3W, 4, destination register index width
- CNTW, 16, stall counter width
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- in_valid  in  1  decode presents a valid instruction
- in_ready  out  1  stage can accept this cycle
- flush  in  1  kill all held and incoming instructions
- RD1_i, RD2_i  in  LANES*N  vector operands
- Extend_i  in  N  extended immediate
- Ctrl_i  in  id_ex_ctrl_t  RF_WE, A3[A3W], BranchSelect[2], ALUOpBSelect, ALUControl[2], SetFlags, MemWE, WBSelect
- out_valid  out  1  execute-side instruction valid
- out_ready  in  1  execute accepts this cycle
- RD1_o, RD2_o  out  LANES*N  registered operands
- Extend_o  out  N  registered immediate
- Ctrl_o  out  id_ex_ctrl_t  registered control, strobes gated
- stall_cnt  out  CNTW  cycles with in_valid && !in_ready, saturating

## Operation
- accept = in_valid && in_ready && !flush; pop = out_valid && out_ready.
- Storage consists of a main entry, which drives the outputs, and a skid entry.
- States EMPTY, ONE, FULL. in_ready = (state != FULL), decoded from the state register only.
- EMPTY: on accept, load main and go to ONE.
- ONE:
  - accept && pop: load main with the new instruction, stay in ONE.
  - accept && !pop: load skid, go to FULL.
  - pop only: go to EMPTY.
  - otherwise hold.
- FULL: no accept is possible. On pop, move skid to main and go to ONE. Otherwise hold.
- flush: next state is EMPTY from any state, and any concurrent input is dropped. Flush takes priority over accept and pop. It does not clear stall_cnt.
- out_valid = (state != EMPTY).
- When out_valid=0, Ctrl_o.RF_WE, MemWE and SetFlags are forced to 0, and BranchSelect is forced to 0.
- When out_valid=0, RD1_o, RD2_o, Extend_o and the other Ctrl_o fields hold their last value. These values are don't-care.
- stall_cnt increments by 1 per cycle while in_valid && !in_ready. It saturates at 2^CNTW-1 and never wraps.
- Data is passed unmodified. There is no width conversion.

## Timing
- Latency is 1 cycle: an instruction accepted at edge k appears on the outputs after edge k with out_valid=1.
- Throughput is 1 per cycle while out_ready stays high.
- There is no combinational path from out_ready or flush to in_ready. Combinational paths exist only from state to the outputs.
- When out_ready drops while in ONE with in_valid high, one more instruction is absorbed into skid. in_ready falls on the next cycle.
- Order is preserved: the skid entry always issues after the main entry.
- Reset values:
  - state is EMPTY.
  - out_valid, all RD1_o/RD2_o/Extend_o bits, all Ctrl_o fields and stall_cnt are 0.
  - in_ready is 1.
- RST asserted mid-operation discards both entries immediately, without waiting for a clock edge.
- Flush takes effect at the next edge: out_valid is 0 in the following cycle, and in_ready is 1.

## Structure
- Package pipe_pkg contains:
  - id_ex_ctrl_t, a packed struct of the control fields, with A3 width fixed to 4 to match the register file.
  - the skid state enum pipe_state_t {EMPTY, ONE, FULL}.
  - constant CTRL_NOP, the all-zero control word.
- Sub-module pipe_skid_buf is a generic valid/ready two-entry skid buffer, parametrised by payload width, with a flush input.
- pipe_id_ex_skid instantiates pipe_skid_buf with payload {RD1, RD2, Extend, Ctrl}. It then adds strobe gating and the stall counter.

## Test plan
- Streaming: in_valid=1 and out_ready=1 for 8 cycles, RD1_i lane0=1..8 → out_valid=1 from cycle 1, RD1_o lane0=1..8 in order, stall_cnt=0.
- Backpressure: out_ready=0 in ONE, in_valid=1 with values A then B → state FULL, in_ready=0 next cycle. With out_ready=1, A then B emerge and in_ready returns to 1.
- Flush in FULL while in_valid=1 (value C) and out_ready=1 → next cycle out_valid=0 and Ctrl_o.RF_WE=MemWE=SetFlags=0. C is never emitted.
- Bubble gating: in_valid=0 for 2 cycles after an instruction with RF_WE=1, MemWE=1 → out_valid=0 and both strobes 0 in the bubble cycles.
- Stall counter with CNTW=4: hold in_valid=1, out_ready=0 for 20 cycles → stall_cnt reaches 15 and stays at 15.
- Async reset: assert RST between edges in FULL → out_valid=0, all outputs 0, in_ready=1, stall_cnt=0 immediately, without a clock edge.
